// File: rtl/adc_interleave_seq.sv
// Selects one of NUM_CH interleaved sub-ADC samples onto a registered x_adc output,
// either by an external channel select or by an internal round-robin sequencer.
module adc_interleave_seq #(
   parameter int DATA_W = 32,
   parameter int NUM_CH = 32,
   parameter int SEL_W  = 5
) (
   input  logic                     clk,
   input  logic                     GlobalReset,
   input  logic [NUM_CH*DATA_W-1:0] x_adc_bus,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         manual_sel,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     cont,
   input  logic                     step_en,
   output logic [DATA_W-1:0]        x_adc,
   output logic                     x_adc_valid,
   output logic [SEL_W-1:0]         x_adc_ch,
   output logic                     frame_done,
   output logic                     busy
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(NUM_CH - 1);
   localparam logic [SEL_W:0]   NUM_CH_EX = (SEL_W+1)'(NUM_CH);

   state_t              state;
   logic [SEL_W-1:0]    counter;
   logic                stop_pending;
   logic [SEL_W-1:0]    sel_idx;
   logic [DATA_W-1:0]   sel_sample;

   // Out-of-range manual selects fall back to channel 0.
   always_comb begin
      sel_idx = '0;
      if (state == RUN) begin
         sel_idx = counter;
      end else if ({1'b0, manual_sel} < NUM_CH_EX) begin
         sel_idx = manual_sel;
      end
   end

   always_comb begin
      sel_sample = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (sel_idx == SEL_W'(k)) begin
            sel_sample = x_adc_bus[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         state        <= IDLE;
         counter      <= '0;
         stop_pending <= 1'b0;
         x_adc        <= '0;
         x_adc_valid  <= 1'b0;
         x_adc_ch     <= '0;
         frame_done   <= 1'b0;
         busy         <= 1'b0;
      end else begin
         x_adc_valid <= 1'b0;
         frame_done  <= 1'b0;
         case (state)
            IDLE: begin
               stop_pending <= 1'b0;
               if (!mode) begin
                  if (step_en) begin
                     x_adc       <= sel_sample;
                     x_adc_ch    <= sel_idx;
                     x_adc_valid <= 1'b1;
                  end
               end else if (start && !stop) begin
                  state   <= RUN;
                  counter <= '0;
                  busy    <= 1'b1;
               end
            end
            RUN: begin
               if (stop) begin
                  stop_pending <= 1'b1;
               end
               if (step_en) begin
                  x_adc       <= sel_sample;
                  x_adc_ch    <= counter;
                  x_adc_valid <= 1'b1;
                  // Frame end: a stop seen this cycle or earlier ends the run here.
                  if (counter == LAST_CH) begin
                     frame_done <= 1'b1;
                     counter    <= '0;
                     if (!cont || stop_pending || stop) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        stop_pending <= 1'b0;
                     end
                  end else begin
                     counter <= counter + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_interleave_seq.sv
// Scoreboard bench for adc_interleave_seq with four 8-bit channels.
module tb_adc_interleave_seq;

   localparam int DATA_W = 8;
   localparam int NUM_CH = 4;
   localparam int SEL_W  = 3;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [SEL_W-1:0]  ch;
      logic              fd;
   } exp_t;

   logic                     clk;
   logic                     GlobalReset;
   logic [NUM_CH*DATA_W-1:0] x_adc_bus;
   logic                     mode;
   logic [SEL_W-1:0]         manual_sel;
   logic                     start;
   logic                     stop;
   logic                     cont;
   logic                     step_en;
   logic [DATA_W-1:0]        x_adc;
   logic                     x_adc_valid;
   logic [SEL_W-1:0]         x_adc_ch;
   logic                     frame_done;
   logic                     busy;

   exp_t exp_q[$];
   int   testsRun = 0;
   int   testsFailed = 0;

   adc_interleave_seq #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
      .clk         (clk),
      .GlobalReset (GlobalReset),
      .x_adc_bus   (x_adc_bus),
      .mode        (mode),
      .manual_sel  (manual_sel),
      .start       (start),
      .stop        (stop),
      .cont        (cont),
      .step_en     (step_en),
      .x_adc       (x_adc),
      .x_adc_valid (x_adc_valid),
      .x_adc_ch    (x_adc_ch),
      .frame_done  (frame_done),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs starting just after a rising edge.
   task automatic applyStimulus(input logic m, input logic [SEL_W-1:0] sel, input logic st,
                                input logic sp, input logic c, input logic se);
      mode       = m;
      manual_sel = sel;
      start      = st;
      stop       = sp;
      cont       = c;
      step_en    = se;
      @(posedge clk);
      #1;
   endtask

   task automatic pushExp(input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] ch, input logic fd);
      exp_t e;
      e.data = d;
      e.ch   = ch;
      e.fd   = fd;
      exp_q.push_back(e);
   endtask

   // Every valid output must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (GlobalReset) begin
         if (x_adc_valid) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_valid", {31'd0, x_adc_valid}, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               checkOutput("sb_data", 32'(x_adc), 32'(e.data));
               checkOutput("sb_ch", 32'(x_adc_ch), 32'(e.ch));
               checkOutput("sb_frame_done", {31'd0, frame_done}, {31'd0, e.fd});
            end
         end else begin
            checkOutput("frame_done_without_valid", {31'd0, frame_done}, 32'd0);
         end
      end
   end

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_x_adc"}, 32'(x_adc), 32'd0);
      checkOutput({tag, "_valid"}, {31'd0, x_adc_valid}, 32'd0);
      checkOutput({tag, "_ch"}, 32'(x_adc_ch), 32'd0);
      checkOutput({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      x_adc_bus   = {8'h43, 8'h32, 8'h21, 8'h10};
      GlobalReset = 1'b0;
      mode = 1'b0; manual_sel = '0; start = 1'b0; stop = 1'b0; cont = 1'b0; step_en = 1'b0;
      #3;
      checkResetOutputs("reset");
      @(posedge clk);
      #2;
      GlobalReset = 1'b1;
      @(posedge clk);
      #1;

      // Manual select of channel 2.
      pushExp(8'h32, 3'd2, 1'b0);
      applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("manual_hold_valid", {31'd0, x_adc_valid}, 32'd0);
      checkOutput("manual_hold_data", 32'(x_adc), 32'h32);

      // Single auto frame.
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("single_busy_on", {31'd0, busy}, 32'd1);
      for (int k = 0; k < NUM_CH; k++) begin
         pushExp(8'h10 + 8'(k * 8'h11), 3'(k), k == NUM_CH - 1);
         applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      checkOutput("single_busy_off", {31'd0, busy}, 32'd0);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("single_idle_after", {31'd0, busy}, 32'd0);

      // Continuous frames with a two-cycle stall after channel 1.
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      pushExp(8'h10, 3'd0, 1'b0);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      pushExp(8'h21, 3'd1, 1'b0);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         checkOutput("stall_valid", {31'd0, x_adc_valid}, 32'd0);
         checkOutput("stall_data", 32'(x_adc), 32'h21);
      end
      pushExp(8'h32, 3'd2, 1'b0);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      pushExp(8'h43, 3'd3, 1'b1);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("cont_busy_after_wrap", {31'd0, busy}, 32'd1);
      pushExp(8'h10, 3'd0, 1'b0);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);

      // Stop with counter at 1: the frame completes, then the block idles.
      pushExp(8'h21, 3'd1, 1'b0);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      pushExp(8'h32, 3'd2, 1'b0);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      pushExp(8'h43, 3'd3, 1'b1);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("stop_busy_off", {31'd0, busy}, 32'd0);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);

      // Start and stop together: stop wins.
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
      checkOutput("startstop_busy", {31'd0, busy}, 32'd0);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("startstop_busy2", {31'd0, busy}, 32'd0);
      checkOutput("startstop_valid", {31'd0, x_adc_valid}, 32'd0);

      // Reset mid-frame once the counter has reached channel 2.
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      pushExp(8'h10, 3'd0, 1'b0);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      pushExp(8'h21, 3'd1, 1'b0);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      GlobalReset = 1'b0;
      #1;
      checkResetOutputs("midreset");
      @(posedge clk);
      #2;
      GlobalReset = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
         checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);
         checkOutput("post_reset_valid", {31'd0, x_adc_valid}, 32'd0);
      end

      // Out-of-range manual select falls back to channel 0.
      pushExp(8'h10, 3'd0, 1'b0);
      applyStimulus(1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      #1;
      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
